// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//
// Pipeline hazard controller for the five-stage core. It produces:
//   * Execute-stage operand forwarding selects (ForwardAE / ForwardBE),
//   * per-register stall (enable) and synchronous-clear (flush) controls,
//   * a stall performance counter.
//
// Hazards handled:
//   * load-use: a load in Execute whose destination is read in Decode,
//   * control:  a taken branch/jump resolved in Execute,
//   * memory:   every load is held in Memory for MEM_WAIT_CYCLES extra
//               cycles while the data memory completes.
//
// Each pipeline register in the datapath is wired as
//   en = ~Stall<stage>, rst = Flush<stage>.
//
// Ports
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   Rs1D, Rs2D               source registers of the instruction in Decode
//   Rs1E, Rs2E, RdE          source / destination registers in Execute
//   RdM, RdW                 destination registers in Memory / Writeback
//   ResultSrcE, ResultSrcM   result select in Execute / Memory (2'b01 = load)
//   RegWriteM, RegWriteW     register write enables in Memory / Writeback
//   PCSrcE                   taken branch or jump in Execute
//   ForwardAE, ForwardBE     00 = register file, 01 = Writeback, 10 = Memory
//   StallF..StallM           hold PC / D / E / M registers
//   FlushD, FlushE, FlushW   clear D / E / W registers
//   StallCount               cycles with StallF asserted, saturating
// ---------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_ADDR_WIDTH  = 5,
  parameter int MEM_WAIT_CYCLES = 2,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2D,
  input  logic [REG_ADDR_WIDTH-1:0] Rs1E,
  input  logic [REG_ADDR_WIDTH-1:0] Rs2E,
  input  logic [REG_ADDR_WIDTH-1:0] RdE,
  input  logic [REG_ADDR_WIDTH-1:0] RdM,
  input  logic [REG_ADDR_WIDTH-1:0] RdW,
  input  logic [1:0]                ResultSrcE,
  input  logic [1:0]                ResultSrcM,
  input  logic                      RegWriteM,
  input  logic                      RegWriteW,
  input  logic                      PCSrcE,
  output logic [1:0]                ForwardAE,
  output logic [1:0]                ForwardBE,
  output logic                      StallF,
  output logic                      StallD,
  output logic                      StallE,
  output logic                      StallM,
  output logic                      FlushD,
  output logic                      FlushE,
  output logic                      FlushW,
  output logic [CNT_WIDTH-1:0]      StallCount
);

  // Result-select encoding that marks a load.
  localparam logic [1:0] RES_LOAD = 2'b01;

  // Forwarding select encodings.
  localparam logic [1:0] FWD_RF  = 2'b00;
  localparam logic [1:0] FWD_WB  = 2'b01;
  localparam logic [1:0] FWD_MEM = 2'b10;

  // Memory-wait state machine encodings.
  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_WAIT = 1'b1;

  // The wait counter only has to hold MEM_WAIT_CYCLES-1; keep at least 1 bit
  // so the design still elaborates when the wait is disabled.
  localparam int CW = (MEM_WAIT_CYCLES > 1) ? $clog2(MEM_WAIT_CYCLES) : 1;
  localparam logic [CW-1:0] CNT_LOAD =
    (MEM_WAIT_CYCLES > 0) ? CW'(MEM_WAIT_CYCLES - 1) : '0;
  localparam bit MEM_WAIT_EN = (MEM_WAIT_CYCLES > 0);

  // -------------------------------------------------------------------------
  // Forwarding
  // -------------------------------------------------------------------------
  // Memory has priority because it holds the younger result. A load in
  // Memory has no data yet (only an address), so it is never a source; the
  // load-use stall guarantees the consumer instead picks it up from
  // Writeback. Register x0 is hard-wired to zero and is never forwarded.
  function automatic logic [1:0] fwd_sel(
    input logic [REG_ADDR_WIDTH-1:0] rs,
    input logic [REG_ADDR_WIDTH-1:0] rd_m,
    input logic [REG_ADDR_WIDTH-1:0] rd_w,
    input logic                      reg_write_m,
    input logic                      reg_write_w,
    input logic [1:0]                result_src_m
  );
    logic [1:0] sel;
    sel = FWD_RF;
    if (reg_write_m && (rd_m != '0) && (rd_m == rs) && (result_src_m != RES_LOAD))
      sel = FWD_MEM;
    else if (reg_write_w && (rd_w != '0) && (rd_w == rs))
      sel = FWD_WB;
    return sel;
  endfunction

  logic [1:0] fwd_a;
  logic [1:0] fwd_b;

  assign fwd_a = fwd_sel(Rs1E, RdM, RdW, RegWriteM, RegWriteW, ResultSrcM);
  assign fwd_b = fwd_sel(Rs2E, RdM, RdW, RegWriteM, RegWriteW, ResultSrcM);

  // -------------------------------------------------------------------------
  // Load-use hazard: the instruction in Decode needs a value that the load
  // in Execute has not fetched yet, so Decode and Fetch hold for one cycle
  // and a bubble is inserted into Execute.
  // -------------------------------------------------------------------------
  logic lw_stall;

  assign lw_stall = (ResultSrcE == RES_LOAD) && (RdE != '0) &&
                    ((RdE == Rs1D) || (RdE == Rs2D));

  // -------------------------------------------------------------------------
  // Memory-wait state machine
  // -------------------------------------------------------------------------
  // IDLE sees a new load in Memory and stalls immediately; WAIT counts the
  // remaining stalled cycles down. The cycle in which WAIT sees cnt==0 is the
  // unstalled cycle in which the load leaves Memory, so a following load is
  // recognised afresh by IDLE on the next cycle.
  logic [0:0]    state;
  logic [0:0]    state_nxt;
  logic [CW-1:0] cnt;
  logic [CW-1:0] cnt_nxt;
  logic          mem_stall;

  always_comb begin
    // NOTE: every variable driven here gets a default first so no path can
    // leave it unassigned and infer a latch.
    state_nxt = state;
    cnt_nxt   = cnt;
    mem_stall = 1'b0;
    case (state)
      S_IDLE: begin
        if (MEM_WAIT_EN && (ResultSrcM == RES_LOAD)) begin
          mem_stall = 1'b1;
          state_nxt = S_WAIT;
          cnt_nxt   = CNT_LOAD;
        end
      end
      S_WAIT: begin
        if (cnt != '0) begin
          mem_stall = 1'b1;
          cnt_nxt   = cnt - CW'(1);
        end else begin
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
        cnt_nxt   = '0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of block ordering.
    if (rst) begin
      // A reset arriving mid-wait simply abandons the wait.
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // -------------------------------------------------------------------------
  // Stall / flush outputs
  // -------------------------------------------------------------------------
  // While Memory holds, everything upstream holds with it and a bubble goes
  // into Writeback. A taken branch stuck in Execute keeps PCSrcE high, so its
  // flushes are simply deferred to the first cycle the memory stall drops;
  // flushing earlier would destroy the held Decode/Execute contents.
  // A load-use stall together with a taken branch still stalls Fetch/Decode,
  // but the Decode instruction is wrong-path and is flushed anyway.
  always_comb begin
    ForwardAE = FWD_RF;
    ForwardBE = FWD_RF;
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b1;
    FlushE    = 1'b1;
    FlushW    = 1'b1;
    if (!rst) begin
      ForwardAE = fwd_a;
      ForwardBE = fwd_b;
      StallF    = lw_stall | mem_stall;
      StallD    = lw_stall | mem_stall;
      StallE    = mem_stall;
      StallM    = mem_stall;
      FlushD    = PCSrcE & ~mem_stall;
      FlushE    = (lw_stall | PCSrcE) & ~mem_stall;
      FlushW    = mem_stall;
    end
  end

  // -------------------------------------------------------------------------
  // Stall performance counter (saturating)
  // -------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      StallCount <= '0;
    end else if (StallF && (StallCount != '1)) begin
      StallCount <= StallCount + CNT_WIDTH'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//
// Directed bench for hazard_unit. A vector table covers the combinational
// forwarding / load-use / branch behaviour from a clean IDLE state; short
// hand-written sequences cover reset, the memory-wait stall, back-to-back
// loads, a branch held under a memory stall, and reset mid-wait. A second
// instance with MEM_WAIT_CYCLES=0 shares the inputs.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

  logic       clk;
  logic       rst;
  logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
  logic [1:0] ResultSrcE, ResultSrcM;
  logic       RegWriteM, RegWriteW, PCSrcE;

  // Instance with the default two-cycle memory wait.
  logic [1:0]  fa0, fb0;
  logic        sf0, sd0, se0, sm0, fd0, fe0, fw0;
  logic [31:0] cnt0;

  // Instance with the memory wait disabled.
  logic [1:0]  fa1, fb1;
  logic        sf1, sd1, se1, sm1, fd1, fe1, fw1;
  logic [31:0] cnt1;

  // Control bundle order: {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW}
  logic [6:0] ctl0, ctl1;
  assign ctl0 = {sf0, sd0, se0, sm0, fd0, fe0, fw0};
  assign ctl1 = {sf1, sd1, se1, sm1, fd1, fe1, fw1};

  localparam logic [6:0] C_IDLE = 7'b0000000;
  localparam logic [6:0] C_MEM  = 7'b1111001;
  localparam logic [6:0] C_LW   = 7'b1100010;
  localparam logic [6:0] C_BR   = 7'b0000110;
  localparam logic [6:0] C_LWBR = 7'b1100110;
  localparam logic [6:0] C_RST  = 7'b0000111;

  hazard_unit #(.REG_ADDR_WIDTH(5), .MEM_WAIT_CYCLES(2), .CNT_WIDTH(32)) dut (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .ForwardAE(fa0), .ForwardBE(fb0),
    .StallF(sf0), .StallD(sd0), .StallE(se0), .StallM(sm0),
    .FlushD(fd0), .FlushE(fe0), .FlushW(fw0), .StallCount(cnt0)
  );

  hazard_unit #(.REG_ADDR_WIDTH(5), .MEM_WAIT_CYCLES(0), .CNT_WIDTH(32)) dut_nowait (
    .clk(clk), .rst(rst),
    .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E), .RdE(RdE),
    .RdM(RdM), .RdW(RdW), .ResultSrcE(ResultSrcE), .ResultSrcM(ResultSrcM),
    .RegWriteM(RegWriteM), .RegWriteW(RegWriteW), .PCSrcE(PCSrcE),
    .ForwardAE(fa1), .ForwardBE(fb1),
    .StallF(sf1), .StallD(sd1), .StallE(se1), .StallM(sm1),
    .FlushD(fd1), .FlushE(fe1), .FlushW(fw1), .StallCount(cnt1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw;
    logic [1:0] rse, rsm;
    logic       rwm, rww, pcsrc;
    logic [1:0] fa, fb;
    logic [6:0] ctl;
  } vec_t;

  task automatic apply(input vec_t v);
    Rs1D = v.rs1d; Rs2D = v.rs2d; Rs1E = v.rs1e; Rs2E = v.rs2e;
    RdE = v.rde; RdM = v.rdm; RdW = v.rdw;
    ResultSrcE = v.rse; ResultSrcM = v.rsm;
    RegWriteM = v.rwm; RegWriteW = v.rww; PCSrcE = v.pcsrc;
  endtask

  task automatic clear_inputs();
    Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0; RdE = '0; RdM = '0; RdW = '0;
    ResultSrcE = 2'b00; ResultSrcM = 2'b00;
    RegWriteM = 1'b0; RegWriteW = 1'b0; PCSrcE = 1'b0;
  endtask

  vec_t vecs[13];

  initial begin
    // rs1d   rs2d   rs1e   rs2e   rde    rdm    rdw    rse    rsm    rwm   rww   pc    fa     fb     ctl
    vecs[0]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b00, C_IDLE};
    vecs[1]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd0, 5'd5, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, C_IDLE};
    vecs[2]  = '{5'd0, 5'd0, 5'd5, 5'd0, 5'd0, 5'd5, 5'd5, 2'b00, 2'b01, 1'b1, 1'b1, 1'b0, 2'b01, 2'b00, C_MEM};
    vecs[3]  = '{5'd0, 5'd0, 5'd9, 5'd9, 5'd0, 5'd9, 5'd9, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b10, 2'b10, C_IDLE};
    vecs[4]  = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd3, 5'd3, 2'b00, 2'b00, 1'b0, 1'b1, 1'b0, 2'b00, 2'b01, C_IDLE};
    vecs[5]  = '{5'd0, 5'd0, 5'd0, 5'd3, 5'd0, 5'd3, 5'd3, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_IDLE};
    vecs[6]  = '{5'd0, 5'd7, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_LW};
    vecs[7]  = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_IDLE};
    vecs[8]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_LW};
    vecs[9]  = '{5'd7, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, C_IDLE};
    vecs[10] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, C_BR};
    vecs[11] = '{5'd4, 5'd0, 5'd0, 5'd0, 5'd4, 5'd0, 5'd0, 2'b01, 2'b00, 1'b0, 1'b0, 1'b1, 2'b00, 2'b00, C_LWBR};
    vecs[12] = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 5'd0, 2'b00, 2'b00, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, C_IDLE};

    clear_inputs();
    rst = 1'b1;

    // ---- Reset held two cycles with hazard-looking inputs present ----
    RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5; ResultSrcM = 2'b01; PCSrcE = 1'b1;
    tick(); #2;
    check("rst_c1_ctl", 32'(ctl0), 32'(C_RST));
    check("rst_c1_fwdA", 32'(fa0), 32'd0);
    tick(); #2;
    check("rst_c2_ctl", 32'(ctl0), 32'(C_RST));
    check("rst_c2_fwdA", 32'(fa0), 32'd0);
    rst = 1'b0;
    clear_inputs();
    tick(); #2;
    check("post_rst_ctl", 32'(ctl0), 32'(C_IDLE));
    check("post_rst_cnt", cnt0, 32'd0);

    // ---- Vector table, each applied from a fresh reset ----
    for (int i = 0; i < 13; i++) begin
      rst = 1'b1;
      tick();
      rst = 1'b0;
      apply(vecs[i]);
      #2;
      check($sformatf("v%0d_fwdA", i), 32'(fa0), 32'(vecs[i].fa));
      check($sformatf("v%0d_fwdB", i), 32'(fb0), 32'(vecs[i].fb));
      check($sformatf("v%0d_ctl", i), 32'(ctl0), 32'(vecs[i].ctl));
    end

    // ---- Memory wait: load held in Memory, then a back-to-back load ----
    rst = 1'b1; clear_inputs();
    tick();
    rst = 1'b0;
    ResultSrcM = 2'b01;                    // load arrives in Memory
    #2;
    check("mw_a_ctl", 32'(ctl0), 32'(C_MEM));
    check("mw_a_nowait_ctl", 32'(ctl1), 32'(C_IDLE));
    tick(); #2;
    check("mw_b_ctl", 32'(ctl0), 32'(C_MEM));
    tick(); #2;
    check("mw_c_ctl", 32'(ctl0), 32'(C_IDLE)); // load leaves this cycle
    check("mw_c_cnt", cnt0, 32'd2);
    tick(); #2;                            // second load now in Memory
    check("mw2_a_ctl", 32'(ctl0), 32'(C_MEM));
    tick(); #2;
    check("mw2_b_ctl", 32'(ctl0), 32'(C_MEM));
    tick(); #2;
    check("mw2_c_ctl", 32'(ctl0), 32'(C_IDLE));
    ResultSrcM = 2'b00;
    tick(); #2;
    check("mw2_d_ctl", 32'(ctl0), 32'(C_IDLE));
    check("mw2_d_cnt", cnt0, 32'd4);
    check("nowait_cnt", cnt1, 32'd0);

    // ---- Taken branch held under a memory stall ----
    rst = 1'b1; clear_inputs();
    tick();
    rst = 1'b0;
    ResultSrcM = 2'b01; PCSrcE = 1'b1;
    #2;
    check("br_a_ctl", 32'(ctl0), 32'(C_MEM));
    tick(); #2;
    check("br_b_ctl", 32'(ctl0), 32'(C_MEM));
    tick(); #2;
    check("br_c_ctl", 32'(ctl0), 32'(C_BR));
    check("br_c_nowait_ctl", 32'(ctl1), 32'(C_BR));

    // ---- Reset pulsed while in WAIT ----
    rst = 1'b1; clear_inputs();
    tick();
    rst = 1'b0;
    ResultSrcM = 2'b01;
    #2;
    check("rw_a_ctl", 32'(ctl0), 32'(C_MEM));
    tick();                                // now in WAIT with cnt=1
    rst = 1'b1;
    #2;
    check("rw_rst_ctl", 32'(ctl0), 32'(C_RST));
    tick();
    rst = 1'b0;
    ResultSrcM = 2'b00;
    #2;
    check("rw_after_ctl", 32'(ctl0), 32'(C_IDLE));
    check("rw_after_cnt", cnt0, 32'd0);
    tick(); #2;
    check("rw_after2_ctl", 32'(ctl0), 32'(C_IDLE));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
